// File: rtl/turbine_fifo_sequencer_pkg.sv
// rtl/turbine_fifo_sequencer_pkg.sv - shared constants for the turbine FIFO burst sequencer
package turbine_fifo_sequencer_pkg;

  // Burst length follows the solver's global turbine count.
  localparam int N_WIND_TURBINE = 8;
  localparam int N_TURB_DEF     = N_WIND_TURBINE;
  localparam int DEPTH_DEF      = 16;
  localparam int AW_DEF         = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WR    = 2'd1;
  localparam logic [1:0] ST_RD    = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/turbine_fifo_sequencer_if.sv
// rtl/turbine_fifo_sequencer_if.sv - control and FIFO-side signals of the turbine FIFO sequencer
interface turbine_fifo_sequencer_if
  import turbine_fifo_sequencer_pkg::*;
#(
  parameter int N_TURB = N_TURB_DEF,
  parameter int AW     = AW_DEF
);
  localparam int IW = idx_w(N_TURB);

  logic          rst_user;
  logic          wr_start;
  logic          rd_start;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_wrreq;
  logic          fifo_rdreq;
  logic [IW-1:0] wr_idx;
  logic          rd_valid;
  logic [IW-1:0] rd_idx;
  logic [AW-1:0] level;
  logic          busy;
  logic          step_done;
  logic          err_ovf;
  logic          err_unf;
  logic          err_pend;

  modport master (
    input  rst_user, wr_start, rd_start, fifo_full, fifo_empty,
    output fifo_wrreq, fifo_rdreq, wr_idx, rd_valid, rd_idx, level,
           busy, step_done, err_ovf, err_unf, err_pend
  );

  modport slave (
    output rst_user, wr_start, rd_start, fifo_full, fifo_empty,
    input  fifo_wrreq, fifo_rdreq, wr_idx, rd_valid, rd_idx, level,
           busy, step_done, err_ovf, err_unf, err_pend
  );

endinterface

// File: rtl/turbine_fifo_sequencer_burst_counter.sv
// rtl/turbine_fifo_sequencer_burst_counter.sv - per-burst word counter with terminal-count flag
module turbine_fifo_sequencer_burst_counter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  localparam logic [W-1:0] LAST = W'(N - 1);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/turbine_fifo_sequencer.sv
// rtl/turbine_fifo_sequencer.sv - write/read burst sequencer for the per-turbine result FIFO
module turbine_fifo_sequencer
  import turbine_fifo_sequencer_pkg::*;
#(
  parameter int N_TURB = N_TURB_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  turbine_fifo_sequencer_if.master   bus
);
  localparam int IW = idx_w(N_TURB);
  localparam logic [AW:0] N_W     = (AW+1)'(N_TURB);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [1:0]    state, state_nx;
  logic          wr_pend, rd_pend;
  logic [AW-1:0] level;
  logic          err_ovf, err_unf, err_pend;
  logic [IW-1:0] cnt;
  logic          tc;
  logic          in_burst;
  logic          wr_req, rd_req, wr_fits, rd_fits;
  logic          wr_want, rd_want;
  logic          wrreq, rdreq_rd, rdreq_fl, rdreq, flush_empty;

  assign in_burst = (state == ST_WR) || (state == ST_RD);

  turbine_fifo_sequencer_burst_counter #(.N(N_TURB), .W(IW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (!in_burst || bus.rst_user),
    .en   (in_burst),
    .cnt  (cnt),
    .tc   (tc)
  );

  // rst_user aborts immediately, so no request is issued in the abort cycle.
  assign wr_want     = (state == ST_WR) && !bus.rst_user;
  assign rd_want     = (state == ST_RD) && !bus.rst_user;
  assign wrreq       = wr_want && !bus.fifo_full;
  assign rdreq_rd    = rd_want && !bus.fifo_empty;
  assign rdreq_fl    = (state == ST_FLUSH) && !bus.rst_user && (level != '0) && !bus.fifo_empty;
  assign flush_empty = (state == ST_FLUSH) && !bus.rst_user && (level != '0) && bus.fifo_empty;
  assign rdreq       = rdreq_rd || rdreq_fl;

  assign wr_req  = bus.wr_start || wr_pend;
  assign rd_req  = bus.rd_start || rd_pend;
  assign wr_fits = ({1'b0, level} + N_W) <= DEPTH_W;
  assign rd_fits = {1'b0, level} >= N_W;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (wr_req) begin
          if (wr_fits) state_nx = ST_WR;
        end else if (rd_req && rd_fits) begin
          state_nx = ST_RD;
        end
      end
      ST_WR, ST_RD: if (tc) state_nx = ST_IDLE;
      ST_FLUSH:     if (level == '0) state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
    if (bus.rst_user) state_nx = ST_FLUSH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wr_pend  <= 1'b0;
      rd_pend  <= 1'b0;
      level    <= '0;
      err_ovf  <= 1'b0;
      err_unf  <= 1'b0;
      err_pend <= 1'b0;
    end else begin
      state <= state_nx;

      if (flush_empty)  level <= '0;
      else if (wrreq)   level <= level + 1'b1;
      else if (rdreq)   level <= level - 1'b1;

      if (bus.rst_user) begin
        wr_pend  <= 1'b0;
        rd_pend  <= 1'b0;
        err_ovf  <= 1'b0;
        err_unf  <= 1'b0;
        err_pend <= 1'b0;
      end else begin
        if (state == ST_IDLE) begin
          // One decision per idle cycle; a simultaneous read start waits as pending.
          if (wr_req) begin
            wr_pend <= 1'b0;
            if (!wr_fits) err_ovf <= 1'b1;
            if (bus.rd_start) begin
              if (rd_pend) err_pend <= 1'b1;
              else         rd_pend  <= 1'b1;
            end
          end else if (rd_req) begin
            rd_pend <= 1'b0;
            if (!rd_fits) err_unf <= 1'b1;
          end
        end else begin
          if (bus.wr_start) begin
            if (wr_pend) err_pend <= 1'b1;
            else         wr_pend  <= 1'b1;
          end
          if (bus.rd_start) begin
            if (rd_pend) err_pend <= 1'b1;
            else         rd_pend  <= 1'b1;
          end
        end
        if (wr_want && bus.fifo_full) err_ovf <= 1'b1;
        if ((rd_want && bus.fifo_empty) || flush_empty) err_unf <= 1'b1;
      end
    end
  end

  // FIFO q appears one cycle after rdreq; flush reads are never qualified.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_valid  <= 1'b0;
      bus.rd_idx    <= '0;
      bus.step_done <= 1'b0;
    end else begin
      bus.rd_valid  <= rdreq_rd;
      bus.step_done <= rdreq_rd && tc;
      if (rdreq_rd) bus.rd_idx <= cnt;
    end
  end

  assign bus.fifo_wrreq = wrreq;
  assign bus.fifo_rdreq = rdreq;
  assign bus.wr_idx     = (state == ST_WR) ? cnt : '0;
  assign bus.level      = level;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.err_ovf    = err_ovf;
  assign bus.err_unf    = err_unf;
  assign bus.err_pend   = err_pend;

endmodule

// File: tb/tb_turbine_fifo_sequencer.sv
// tb/tb_turbine_fifo_sequencer.sv - directed and randomized checks of turbine_fifo_sequencer
module tb_turbine_fifo_sequencer;
  import turbine_fifo_sequencer_pkg::*;

  localparam int N     = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  turbine_fifo_sequencer_if #(.N_TURB(N), .AW(AW)) bus ();
  turbine_fifo_sequencer #(.N_TURB(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Occupancy of the FIFO being sequenced, plus overrides to fake bad flags.
  int fcnt = 0;
  bit force_full = 1'b0;
  bit force_empty = 1'b0;
  assign bus.fifo_full  = force_full || (fcnt >= DEPTH);
  assign bus.fifo_empty = force_empty || (fcnt == 0);
  always @(posedge clk or posedge rst) begin
    if (rst) fcnt <= 0;
    else     fcnt <= fcnt + int'(bus.fifo_wrreq) - int'(bus.fifo_rdreq);
  end

  int cyc = 0;
  int wr_cyc[$], wr_ix[$], rd_cyc[$], rv_cyc[$], rv_ix[$], sd_cyc[$];
  always @(negedge clk) begin
    if (bus.fifo_wrreq) begin wr_cyc.push_back(cyc); wr_ix.push_back(int'(bus.wr_idx)); end
    if (bus.fifo_rdreq) rd_cyc.push_back(cyc);
    if (bus.rd_valid)   begin rv_cyc.push_back(cyc); rv_ix.push_back(int'(bus.rd_idx)); end
    if (bus.step_done)  sd_cyc.push_back(cyc);
    cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_logs();
    wr_cyc.delete(); wr_ix.delete(); rd_cyc.delete();
    rv_cyc.delete(); rv_ix.delete(); sd_cyc.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit w, input bit r, input bit u);
    bus.wr_start = w; bus.rd_start = r; bus.rst_user = u;
    cycles(1);
    bus.wr_start = 1'b0; bus.rd_start = 1'b0; bus.rst_user = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wrreq"}, bus.fifo_wrreq, 0);
    chk({tag, "_rdreq"}, bus.fifo_rdreq, 0);
    chk({tag, "_wr_idx"}, bus.wr_idx, 0);
    chk({tag, "_rd_valid"}, bus.rd_valid, 0);
    chk({tag, "_rd_idx"}, bus.rd_idx, 0);
    chk({tag, "_level"}, bus.level, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_step_done"}, bus.step_done, 0);
    chk({tag, "_err_ovf"}, bus.err_ovf, 0);
    chk({tag, "_err_unf"}, bus.err_unf, 0);
    chk({tag, "_err_pend"}, bus.err_pend, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int m_level, exp_wr, exp_rv, exp_sd;
    bit m_ovf, m_unf;

    bus.wr_start = 1'b0; bus.rd_start = 1'b0; bus.rst_user = 1'b0;
    rst = 1'b1;
    cycles(3);
    chk_all_zero("reset");
    rst = 1'b0;
    cycles(2);

    // Single write burst then single read burst, cycle-exact.
    clear_logs(); t0 = cyc;
    pulse(1, 0, 0); cycles(12);
    chk("t1_wr_count", wr_cyc.size(), N);
    chk("t1_wr_first", at(wr_cyc, 0), t0 + 1);
    chk("t1_wr_last", at(wr_cyc, N - 1), t0 + N);
    for (int i = 0; i < N; i++) chk("t1_wr_idx", at(wr_ix, i), i);
    chk("t1_level_after_wr", bus.level, N);
    clear_logs(); t0 = cyc;
    pulse(0, 1, 0); cycles(12);
    chk("t1_rd_count", rd_cyc.size(), N);
    chk("t1_rd_first", at(rd_cyc, 0), t0 + 1);
    chk("t1_rv_first", at(rv_cyc, 0), t0 + 2);
    chk("t1_rv_last", at(rv_cyc, N - 1), t0 + N + 1);
    for (int i = 0; i < N; i++) chk("t1_rd_idx", at(rv_ix, i), i);
    chk("t1_sd_count", sd_cyc.size(), 1);
    chk("t1_sd_cycle", at(sd_cyc, 0), t0 + N + 1);
    chk("t1_level_after_rd", bus.level, 0);
    chk("t1_busy", bus.busy, 0);

    // Three writes: the third would overflow.
    clear_logs();
    for (int k = 0; k < 3; k++) begin pulse(1, 0, 0); cycles(19); end
    chk("t2_wr_count", wr_cyc.size(), 2 * N);
    chk("t2_level", bus.level, 2 * N);
    chk("t2_err_ovf", bus.err_ovf, 1);
    pulse(0, 1, 0); cycles(12);
    pulse(0, 1, 0); cycles(12);
    chk("t2_level_drained", bus.level, 0);

    // Read with empty occupancy is rejected.
    clear_logs();
    pulse(0, 1, 0);
    for (int i = 0; i < 4; i++) begin chk("t3_busy", bus.busy, 0); cycles(1); end
    chk("t3_rd_count", rd_cyc.size(), 0);
    chk("t3_err_unf", bus.err_unf, 1);
    pulse(0, 0, 1); cycles(4);
    chk("t3_flush_ovf_clr", bus.err_ovf, 0);
    chk("t3_flush_unf_clr", bus.err_unf, 0);
    chk("t3_flush_busy", bus.busy, 0);

    // Simultaneous write and read at level N.
    pulse(1, 0, 0); cycles(12);
    clear_logs(); t0 = cyc;
    pulse(1, 1, 0); cycles(25);
    chk("t4a_wr_first", at(wr_cyc, 0), t0 + 1);
    chk("t4a_wr_count", wr_cyc.size(), N);
    chk("t4a_rd_first", at(rd_cyc, 0), t0 + N + 2);
    chk("t4a_rd_count", rd_cyc.size(), N);
    chk("t4a_level", bus.level, N);
    chk("t4a_err_pend", bus.err_pend, 0);
    pulse(0, 1, 0); cycles(12);

    // Extra write starts during a burst: one pending, one dropped.
    clear_logs(); t0 = cyc;
    pulse(1, 0, 0); cycles(1);
    pulse(1, 0, 0);
    pulse(1, 0, 0); cycles(25);
    chk("t4b_wr_count", wr_cyc.size(), 2 * N);
    chk("t4b_second_start", at(wr_cyc, N), t0 + N + 2);
    chk("t4b_level", bus.level, 2 * N);
    chk("t4b_err_pend", bus.err_pend, 1);
    chk("t4b_err_ovf", bus.err_ovf, 0);
    clear_logs();
    pulse(0, 0, 1); cycles(25);
    chk("t4b_flush_rd", rd_cyc.size(), 2 * N);
    chk("t4b_flush_rv", rv_cyc.size(), 0);
    chk("t4b_flush_level", bus.level, 0);
    chk("t4b_flush_pend_clr", bus.err_pend, 0);

    // rst_user in the 4th write cycle with a read pending and an error set.
    pulse(0, 1, 0); cycles(2);
    chk("t5_pre_err_unf", bus.err_unf, 1);
    clear_logs(); t0 = cyc;
    pulse(1, 0, 0); cycles(1);
    pulse(0, 1, 0); cycles(1);
    pulse(0, 0, 1); cycles(20);
    chk("t5_wr_count", wr_cyc.size(), 3);
    chk("t5_flush_rd", rd_cyc.size(), 3);
    chk("t5_flush_first", at(rd_cyc, 0), t0 + 5);
    chk("t5_rv_count", rv_cyc.size(), 0);
    chk("t5_level", bus.level, 0);
    chk("t5_err_unf", bus.err_unf, 0);
    chk("t5_busy", bus.busy, 0);

    // Asynchronous reset in the middle of a read burst.
    pulse(1, 0, 0); cycles(12);
    pulse(0, 1, 0); cycles(2);
    rst = 1'b1; #1;
    chk_all_zero("t6_rst");
    cycles(2);
    rst = 1'b0; cycles(2);
    clear_logs();
    pulse(1, 0, 0); cycles(12);
    chk("t6_wr_count", wr_cyc.size(), N);
    chk("t6_level", bus.level, N);
    chk("t6_wr_idx_last", at(wr_ix, N - 1), N - 1);

    // fifo_empty asserted for two cycles of a read burst.
    clear_logs();
    pulse(0, 1, 0); cycles(2);
    force_empty = 1'b1; cycles(2);
    force_empty = 1'b0; cycles(10);
    chk("t7_rd_count", rd_cyc.size(), N - 2);
    chk("t7_rv_count", rv_cyc.size(), N - 2);
    chk("t7_rv_skip", at(rv_ix, 2), 4);
    chk("t7_sd_count", sd_cyc.size(), 1);
    chk("t7_level", bus.level, 2);
    chk("t7_err_unf", bus.err_unf, 1);

    // Flush that finds the FIFO empty while level is non-zero.
    clear_logs();
    force_empty = 1'b1;
    pulse(0, 0, 1); cycles(4);
    force_empty = 1'b0;
    chk("t7_flush_rd", rd_cyc.size(), 0);
    chk("t7_flush_level", bus.level, 0);
    chk("t7_flush_err_unf", bus.err_unf, 1);
    chk("t7_flush_busy", bus.busy, 0);

    // fifo_full asserted for two cycles of a write burst.
    rst = 1'b1; cycles(1); rst = 1'b0; cycles(1);
    clear_logs();
    pulse(1, 0, 0); cycles(1);
    force_full = 1'b1; cycles(2);
    force_full = 1'b0; cycles(10);
    chk("t8_wr_count", wr_cyc.size(), N - 2);
    chk("t8_wr_skip", at(wr_ix, 1), 3);
    chk("t8_level", bus.level, N - 2);
    chk("t8_err_ovf", bus.err_ovf, 1);

    // Random burst commands against a transaction-level occupancy model.
    rst = 1'b1; cycles(1); rst = 1'b0; cycles(1);
    clear_logs();
    m_level = 0; exp_wr = 0; exp_rv = 0; exp_sd = 0; m_ovf = 1'b0; m_unf = 1'b0;
    for (int it = 0; it < 40; it++) begin
      int op;
      bit w, r;
      op = int'($urandom_range(0, 2));
      w = (op != 1);
      r = (op != 0);
      if (w) begin
        if (m_level + N <= DEPTH) begin m_level += N; exp_wr += N; end
        else m_ovf = 1'b1;
      end
      if (r) begin
        if (m_level >= N) begin m_level -= N; exp_rv += N; exp_sd++; end
        else m_unf = 1'b1;
      end
      pulse(w, r, 0);
      cycles(2 * N + 4 + int'($urandom_range(0, 3)));
      chk("rnd_level", bus.level, m_level);
      chk("rnd_err_ovf", bus.err_ovf, m_ovf);
      chk("rnd_err_unf", bus.err_unf, m_unf);
      chk("rnd_wr_count", wr_cyc.size(), exp_wr);
      chk("rnd_rv_count", rv_ix.size(), exp_rv);
      chk("rnd_sd_count", sd_cyc.size(), exp_sd);
      chk("rnd_busy", bus.busy, 0);
    end
    for (int k = 0; k < wr_ix.size(); k++) chk("rnd_wr_idx", wr_ix[k], k % N);
    for (int k = 0; k < rv_ix.size(); k++) chk("rnd_rd_idx", rv_ix[k], k % N);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/turbine_fifo_sequencer.md
Name: turbine_fifo_sequencer

Overview:
Burst controller for the per-turbine 32-bit result FIFO in the wind-turbine real-time solver. Each simulation step it issues exactly N_TURB write requests and, on command, exactly N_TURB read requests. It tracks FIFO occupancy independently of the FIFO, and flags bursts that would overflow or underflow. On a user reset it drains the FIFO, and it tells downstream logic which turbine index each read word belongs to.

Parameters:
N_TURB, 8, words per burst (one per wind turbine); 1..DEPTH
DEPTH, 16, FIFO capacity in words
AW, 5, occupancy counter width; must satisfy 2^AW > DEPTH

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rst_user  in  1  synchronous user flush request, single-cycle pulse
wr_start  in  1  pulse: solver results ready, start write burst
rd_start  in  1  pulse: consumer ready, start read burst
fifo_full  in  1  FIFO full flag (checked only)
fifo_empty  in  1  FIFO empty flag (checked only)
fifo_wrreq  out  1  FIFO write request
fifo_rdreq  out  1  FIFO read request
wr_idx  out  log2(N_TURB)  turbine index of the current write (upstream data-mux select)
rd_valid  out  1  FIFO q holds valid data this cycle
rd_idx  out  log2(N_TURB)  turbine index of the word qualified by rd_valid
level  out  AW  tracked occupancy
busy  out  1  state != IDLE
step_done  out  1  one-cycle pulse with the last rd_valid of a burst
err_ovf  out  1  sticky: write burst rejected, or wrreq while fifo_full
err_unf  out  1  sticky: read burst rejected, or rdreq while fifo_empty
err_pend  out  1  sticky: start request dropped because its pending slot was already set

Behaviour:
- Reset (rst): state IDLE. All outputs 0, including the sticky errors, level and both pending flags.
- States: IDLE, WR_BURST, RD_BURST, FLUSH. One burst counter cnt, 0..N_TURB-1.
- IDLE, acting on wr_start, rd_start or a pending flag:
  - Write has priority over read.
  - Write accepted if level + N_TURB <= DEPTH. Otherwise set err_ovf, clear the request, stay in IDLE.
  - Read accepted if level >= N_TURB. Otherwise set err_unf, clear the request, stay in IDLE.
- Start latency: a start accepted at cycle t gives the first req at t+1. Exactly N_TURB consecutive req cycles, then return to IDLE.
  - A pending request can launch the next burst with one IDLE cycle between bursts.
- WR_BURST: fifo_wrreq = 1; wr_idx = cnt, counting 0..N_TURB-1.
- RD_BURST: fifo_rdreq = 1. rd_valid and rd_idx follow rdreq by one cycle, matching FIFO read latency.
  - step_done is asserted with rd_valid when rd_idx = N_TURB-1.
- Start during a burst or FLUSH: latched into the matching pending flag (one deep).
  - If that flag is already set: set err_pend and drop the request.
  - wr_start and rd_start together in IDLE: write starts, read becomes pending.
- level: +1 per wrreq, -1 per rdreq. Never both in one cycle by construction.
- Safety checks: if fifo_full is seen while wrreq would assert, suppress wrreq and set err_ovf. Same for fifo_empty/rdreq and err_unf. The burst counter still advances so bursts always end.
- rst_user, in any state: abort the current burst, clear both pending flags, enter FLUSH on the next cycle.
  - FLUSH: fifo_rdreq = 1 while level != 0 and !fifo_empty; rd_valid is held 0. IDLE when level = 0.
  - If fifo_empty is seen with level != 0: force level to 0 and set err_unf.
  - Sticky errors are cleared on entering FLUSH.
  - rst_user during FLUSH restarts the flush; no other effect.
- rst asserted mid-burst: immediate return to reset state. No partial-burst bookkeeping survives.

Decomposition:
- Shared package/include: state encodings (ST_IDLE, ST_WR, ST_RD, ST_FLUSH), default N_TURB, DEPTH and AW, tied to the global N_WindTurbine constant.
- One natural sub-module: burst_counter (load, enable, terminal-count flag), instantiated once and reused by WR_BURST and RD_BURST.
- The one-cycle rd_valid/rd_idx alignment is a local register stage, not a sub-module.

Test Plan (N_TURB=8, DEPTH=16):
- wr_start at t=10, then rd_start at t=30:
  - fifo_wrreq high t=11..18 with wr_idx 0..7; level 8 at t=19.
  - fifo_rdreq high t=31..38; rd_valid t=32..39 with rd_idx 0..7; step_done at t=39; level 0.
- Three wr_start pulses spaced 20 cycles apart, no reads: first two accepted (level 16). Third rejected: err_ovf=1, no wrreq, level stays 16.
- rd_start with level=0 -> err_unf=1, no rdreq, busy stays 0.
- wr_start and rd_start in the same IDLE cycle at t=5, with level=8:
  - Write burst t=6..13, then IDLE at t=14, then read burst t=15..22; level returns to 8.
  - Two extra wr_start pulses during the write burst: first pending, second sets err_pend.
- rst_user at the 4th cycle of a write burst (level 3 after that cycle):
  - Burst aborts; FLUSH issues 3 rdreq with rd_valid=0; level 0; back in IDLE.
  - Errors cleared; pending flags cleared.
- rst asserted mid read burst: all outputs 0 in the same cycle. After release, wr_start works normally with level counted from 0.
